// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder.
// The state enum and digit width are used by the controller; cnt_width sizes its digit counter.
package serial_adder_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for WIDTH/DIGIT_W digits, never narrower than one bit.
  function automatic int cnt_width(input int width);
    int n;
    n = $clog2(width / DIGIT_W);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/two_bit_fac.sv
// Two-bit full-adder cell: {carry_out, out} = a + b + carry_in.
// Purely combinational; the controller registers everything around it.
module two_bit_fac (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       carry_in,
  output logic       carry_out,
  output logic [1:0] out
);

  assign {carry_out, out} = {1'b0, a} + {1'b0, b} + {2'b00, carry_in};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Digit-serial adder: captures a, b, carry_in on start and adds them two bits per cycle
// through a single two_bit_fac cell, assembling sum LSB digit first.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH must be even and >= 2");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [DIGIT_W-1:0] w_out;
  logic               w_carry;

  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_dig = r_a[i*DIGIT_W +: DIGIT_W];
        w_b_dig = r_b[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  two_bit_fac u_fac (
    .a         (w_a_dig),
    .b         (w_b_dig),
    .carry_in  (r_carry),
    .carry_out (w_carry),
    .out       (w_out)
  );

  // busy/done are registered from the state, so they trail it by one cycle:
  // busy covers the WIDTH/2 digit cycles and done lands at edge WIDTH/2+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (r_state == ST_RUN);
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= carry_in;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NDIG; i++) begin
            if (r_cnt == CNT_W'(i)) begin
              r_sum[i*DIGIT_W +: DIGIT_W] <= w_out;
            end
          end
          r_carry <= w_carry;
          // Counter holds on the last digit rather than wrapping.
          if (r_cnt == LAST_DIG) begin
            r_cout  <= w_carry;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Drives WIDTH=8, 4 and 2 adders from shared stimulus and checks each against an
// arithmetic reference plus a latency schedule derived from the acceptance edge.
module tb_serial_adder_ctrl;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       carry_in = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
  );
  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .a(a[3:0]), .b(b[3:0]), .carry_in(carry_in),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4)
  );
  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .a(a[1:0]), .b(b[1:0]), .carry_in(carry_in),
    .busy(busy2), .done(done2), .sum(sum2), .carry_out(cout2)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  int         t = 0;
  int         acc[N];
  logic [8:0] ref_res[N];
  bit         res_valid[N];

  function automatic int wid(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 4 : 2);
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference at the edge, compare at the negedge.
  task automatic step(input logic rst, input logic st, input logic [7:0] av,
                      input logic [7:0] bv, input logic ci);
    int         w;
    logic [8:0] mask;
    logic       o_busy, o_done, exp_busy, exp_done;
    logic [8:0] o_res;
    reset = rst; start = st; a = av; b = bv; carry_in = ci;
    @(posedge clk);
    t++;
    for (int i = 0; i < N; i++) begin
      w = wid(i);
      mask = (9'd1 << w) - 9'd1;
      if (rst) begin
        acc[i] = -1;
        res_valid[i] = 1'b1;
        ref_res[i] = '0;
      end else if (st && (acc[i] < 0 || t >= acc[i] + w/2 + 2)) begin
        acc[i] = t;
        res_valid[i] = 1'b0;
        ref_res[i] = ({1'b0, av} & mask) + ({1'b0, bv} & mask) + {8'd0, ci};
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      w = wid(i);
      exp_busy = (acc[i] >= 0) && (t >= acc[i] + 1) && (t <= acc[i] + w/2);
      exp_done = (acc[i] >= 0) && (t == acc[i] + w/2 + 1);
      if (exp_done) res_valid[i] = 1'b1;
      case (i)
        0:       begin o_busy = busy8; o_done = done8; o_res = {cout8, sum8}; end
        1:       begin o_busy = busy4; o_done = done4; o_res = {4'd0, cout4, sum4}; end
        default: begin o_busy = busy2; o_done = done2; o_res = {6'd0, cout2, sum2}; end
      endcase
      check($sformatf("w%0d_busy", w), {8'd0, o_busy}, {8'd0, exp_busy});
      check($sformatf("w%0d_done", w), {8'd0, o_done}, {8'd0, exp_done});
      if (res_valid[i]) check($sformatf("w%0d_result", w), o_res, ref_res[i]);
    end
  endtask

  // Accept one operation, then idle with scrambled operands until every width has finished.
  task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic ci);
    step(1'b0, 1'b1, av, bv, ci);
    repeat (5) step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      acc[i] = -1;
      ref_res[i] = '0;
      res_valid[i] = 1'b0;
    end

    // Reset with start high: start must be ignored and every output zero.
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Directed operands including carry-out and full-wrap cases.
    op(8'hFF, 8'h01, 1'b0);
    op(8'hA5, 8'h5A, 1'b1);
    op(8'h12, 8'h34, 1'b0);

    // Start held high with operands toggling every cycle.
    repeat (30) step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    repeat (6) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset sampled at the end of the second RUN cycle aborts without a done pulse.
    step(1'b0, 1'b1, 8'hC3, 8'h7E, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (6) step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    op(8'h80, 8'h80, 1'b1);

    // Exhaustive for the 4-bit instance; the 2-bit instance sees every combination too.
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int ci = 0; ci < 2; ci++)
          op({4'($urandom), 4'(av)}, {4'($urandom), 4'(bv)}, 1'(ci));

    // Random start/operand/reset traffic.
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
